// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response channel of sram_ctrl; SRAM_BYTE_EN_EN adds the req_be lane mask
interface sram_ctrl_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
`ifdef SRAM_BYTE_EN_EN
  logic [DW/8-1:0] req_be;
`endif
  logic rsp_valid;
  logic [DW-1:0] rsp_rdata;
`ifdef SRAM_BYTE_EN_EN
  modport master(output req_valid, req_we, req_addr, req_wdata, req_be, input req_ready, rsp_valid, rsp_rdata);
  modport slave(input req_valid, req_we, req_addr, req_wdata, req_be, output req_ready, rsp_valid, rsp_rdata);
`else
  modport master(output req_valid, req_we, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata);
  modport slave(input req_valid, req_we, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: async SRAM controller with read/write wait states and write-to-access turnaround
// SRAM_BYTE_EN_EN adds per-byte write lanes (req_be in, sram_be_n out)
module sram_ctrl #(
  parameter int AW = 18,
  parameter int DW = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int TURN = 1
) (
  input  logic clk,
  input  logic rst_n,
  sram_ctrl_if.slave bus,
`ifdef SRAM_BYTE_EN_EN
  output logic [DW/8-1:0] sram_be_n,
`endif
  output logic sram_cs_n,
  output logic sram_oe_n,
  output logic sram_we_n,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  input  logic [DW-1:0] sram_dq_i,
  output logic sram_dq_oe
);
  typedef enum logic [2:0] {S_IDLE, S_RD_ACC, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TURN} state_t;
  state_t state, nxt;
  logic [3:0] cnt, cnt_d;
  logic acc, rd_done, wr_nxt;
`ifdef SRAM_BYTE_EN_EN
  logic [DW/8-1:0] be_q;
`endif
  always_comb begin
    nxt = state;
    cnt_d = '0;
    acc = bus.req_valid && bus.req_ready;
    rd_done = 1'b0;
    case (state)
      S_IDLE: nxt = acc ? (bus.req_we ? S_WR_SETUP : S_RD_ACC) : S_IDLE;
      S_RD_ACC: begin
        rd_done = cnt == 4'(RD_WAIT);
        nxt = rd_done ? S_IDLE : S_RD_ACC;
        cnt_d = rd_done ? '0 : cnt + 4'd1;
      end
      S_WR_SETUP: nxt = S_WR_PULSE;
      S_WR_PULSE: begin
        nxt = cnt == 4'(WR_WAIT) ? S_WR_HOLD : S_WR_PULSE;
        cnt_d = cnt == 4'(WR_WAIT) ? '0 : cnt + 4'd1;
      end
      S_WR_HOLD: nxt = TURN == 0 ? S_IDLE : S_TURN;
      S_TURN: begin
        nxt = cnt == 4'(TURN - 1) ? S_IDLE : S_TURN;
        cnt_d = cnt == 4'(TURN - 1) ? '0 : cnt + 4'd1;
      end
      default: nxt = S_IDLE;
    endcase
    wr_nxt = nxt inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
  end
  // Strobes are registered from the next state, so every pin changes only on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      sram_cs_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_dq_oe <= 1'b0;
`ifdef SRAM_BYTE_EN_EN
      be_q <= '0;
      sram_be_n <= '1;
`endif
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      bus.req_ready <= nxt == S_IDLE;
      bus.rsp_valid <= rd_done;
      if (rd_done) bus.rsp_rdata <= sram_dq_i;
      sram_cs_n <= nxt == S_IDLE || nxt == S_TURN;
      sram_oe_n <= nxt != S_RD_ACC;
      sram_we_n <= nxt != S_WR_PULSE;
      sram_dq_oe <= wr_nxt;
      if (acc) sram_addr <= bus.req_addr;
      if (acc && bus.req_we) sram_dq_o <= bus.req_wdata;
`ifdef SRAM_BYTE_EN_EN
      if (acc) be_q <= bus.req_be;
      sram_be_n <= wr_nxt ? ~(acc ? bus.req_be : be_q) : (nxt == S_RD_ACC ? '0 : '1);
`endif
    end
  end
endmodule
